// File: rtl/alu_result_stage_pkg.sv
// alu_result_stage_pkg: opcodes, flag bit positions and default width shared by the ALU result stage.
package alu_result_stage_pkg;
   localparam int WIDTH_DEF = 4;
   localparam logic [1:0] OP_AND = 2'b00;
   localparam logic [1:0] OP_OR  = 2'b01;
   localparam logic [1:0] OP_XOR = 2'b10;
   localparam logic [1:0] OP_ADD = 2'b11;
   localparam int FLG_N = 3;
   localparam int FLG_Z = 2;
   localparam int FLG_C = 1;
   localparam int FLG_V = 0;
endpackage

// File: rtl/alu_result_stage_if.sv
// alu_result_stage_if: lane inputs, drain handshake and status of the ALU result stage.
interface alu_result_stage_if #(
   parameter int WIDTH = 4,
   parameter int DEPTH = 2
);
   localparam int CW = $clog2(DEPTH) + 1;
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       in_op;
   logic [WIDTH-1:0] res_and;
   logic [WIDTH-1:0] res_or;
   logic [WIDTH-1:0] res_xor;
   logic [WIDTH-1:0] res_add;
   logic             add_cout;
   logic             add_ovf;
   logic             out_valid;
   logic             out_ready;
   logic [1:0]       out_op;
   logic [WIDTH-1:0] out_result;
   logic [3:0]       out_flags;
   logic [CW-1:0]    count;
   logic             ovf_sticky;
   logic             clr_sticky;
   modport master (
      output in_valid, in_op, res_and, res_or, res_xor, res_add, add_cout, add_ovf, out_ready, clr_sticky,
      input  in_ready, out_valid, out_op, out_result, out_flags, count, ovf_sticky
   );
   modport slave (
      input  in_valid, in_op, res_and, res_or, res_xor, res_add, add_cout, add_ovf, out_ready, clr_sticky,
      output in_ready, out_valid, out_op, out_result, out_flags, count, ovf_sticky
   );
endinterface

// File: rtl/alu_result_fifo.sv
// alu_result_fifo: synchronous FIFO with occupancy count; read data is forced to zero while empty.
module alu_result_fifo #(
   parameter int DW    = 10,
   parameter int DEPTH = 2,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = AW + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push_i,
   input  logic          pop_i,
   input  logic [DW-1:0] wdata_i,
   output logic [DW-1:0] rdata_o,
   output logic [CW-1:0] count_o,
   output logic          full_o,
   output logic          empty_o
);
   logic [DW-1:0] mem_q [DEPTH];
   logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
   logic [CW-1:0] count_q, count_d;
   logic          do_push, do_pop;
   always_comb begin
      full_o  = count_q == CW'(DEPTH);
      empty_o = count_q == '0;
      do_push = push_i & ~full_o;
      do_pop  = pop_i & ~empty_o;
      wr_d    = do_push ? wr_q + AW'(1) : wr_q;
      rd_d    = do_pop ? rd_q + AW'(1) : rd_q;
      count_d = count_q + CW'(do_push) - CW'(do_pop);
      rdata_o = empty_o ? '0 : mem_q[rd_q];
      count_o = count_q;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_q    <= '0;
         rd_q    <= '0;
         count_q <= '0;
      end else begin
         wr_q    <= wr_d;
         rd_q    <= rd_d;
         count_q <= count_d;
      end
   end
   always_ff @(posedge clk) begin
      if (do_push) mem_q[wr_q] <= wdata_i;
   end
endmodule

// File: rtl/alu_result_stage.sv
// alu_result_stage: selects the ALU lane result by opcode, derives N/Z/C/V and queues
// {op, result, flags} entries so the lanes are decoupled from a stalling consumer.
module alu_result_stage
   import alu_result_stage_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int DEPTH = 2
) (
   input logic               clk,
   input logic               rst,
   alu_result_stage_if.slave bus
);
   localparam int DW = 2 + WIDTH + 4;
   logic [WIDTH-1:0] result;
   logic [3:0]       flags;
   logic             is_add, push, pop, full, empty;
   logic             ovf_sticky_q, ovf_sticky_d;
   logic [DW-1:0]    rdata;
   always_comb begin
      is_add       = bus.in_op == OP_ADD;
      result       = bus.in_op == OP_AND ? bus.res_and :
                     bus.in_op == OP_OR  ? bus.res_or  :
                     bus.in_op == OP_XOR ? bus.res_xor : bus.res_add;
      flags        = '0;
      flags[FLG_N] = result[WIDTH-1];
      flags[FLG_Z] = result == '0;
      flags[FLG_C] = is_add & bus.add_cout;
      flags[FLG_V] = is_add & bus.add_ovf;
      push         = bus.in_valid & ~full & ~rst;
      pop          = bus.out_ready & ~empty;
      ovf_sticky_d = (ovf_sticky_q | (push & flags[FLG_V])) & ~bus.clr_sticky;
   end
   always_ff @(posedge clk) begin
      if (rst) ovf_sticky_q <= 1'b0;
      else     ovf_sticky_q <= ovf_sticky_d;
   end
   alu_result_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push_i  (push),
      .pop_i   (pop),
      .wdata_i ({bus.in_op, result, flags}),
      .rdata_o (rdata),
      .count_o (bus.count),
      .full_o  (full),
      .empty_o (empty)
   );
   assign bus.in_ready   = ~full & ~rst;
   assign bus.out_valid  = ~empty;
   assign bus.ovf_sticky = ovf_sticky_q;
   assign {bus.out_op, bus.out_result, bus.out_flags} = rdata;
endmodule

// File: tb/tb_alu_result_stage.sv
// tb_alu_result_stage: scoreboard bench for the ALU result stage (lane select, flags, FIFO, sticky overflow).
module tb_alu_result_stage;
   localparam int DEPTH = 2;
   typedef struct packed {
      logic [1:0] op;
      logic [3:0] res;
      logic [3:0] flg;
   } ent_t;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   pass_cnt = 0;
   int   total_cnt = 0;
   int   mcount = 0;
   logic msticky = 1'b0;
   ent_t sb[$];
   alu_result_stage_if #(.WIDTH(4), .DEPTH(DEPTH)) bus ();
   alu_result_stage #(.WIDTH(4), .DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   function automatic ent_t model(logic [1:0] op, logic [3:0] a, logic [3:0] o, logic [3:0] x,
                                  logic [3:0] s, logic c, logic v);
      ent_t e;
      e.op = op;
      case (op)
         2'd0:    e.res = a;
         2'd1:    e.res = o;
         2'd2:    e.res = x;
         default: e.res = s;
      endcase
      e.flg = {e.res[3], e.res == 4'd0, (op == 2'd3) && c, (op == 2'd3) && v};
      return e;
   endfunction
   task automatic set_in(logic valid, logic [1:0] op, logic [3:0] a, logic [3:0] o, logic [3:0] x,
                         logic [3:0] s, logic c, logic v);
      bus.in_valid = valid;
      bus.in_op    = op;
      bus.res_and  = a;
      bus.res_or   = o;
      bus.res_xor  = x;
      bus.res_add  = s;
      bus.add_cout = c;
      bus.add_ovf  = v;
   endtask
   task automatic rand_in();
      set_in(1'b1, 2'($urandom_range(0, 3)), 4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
             1'($urandom), 1'($urandom));
   endtask
   // Samples the head before the edge, then advances the model by the handshakes that edge performs.
   task automatic tick(output logic pu, output logic po, output ent_t exp, output ent_t act);
      ent_t nxt;
      act = {bus.out_op, bus.out_result, bus.out_flags};
      exp = '0;
      nxt = model(bus.in_op, bus.res_and, bus.res_or, bus.res_xor, bus.res_add, bus.add_cout, bus.add_ovf);
      pu  = !rst && bus.in_valid && mcount < DEPTH;
      po  = !rst && bus.out_ready && mcount != 0;
      if (po) exp = sb.pop_front();
      if (rst) begin
         sb.delete();
         mcount  = 0;
         msticky = 1'b0;
      end else begin
         if (pu) sb.push_back(nxt);
         mcount  = mcount + int'(pu) - int'(po);
         msticky = (msticky | (pu & nxt.flg[0])) & ~bus.clr_sticky;
      end
      @(posedge clk);
      #1;
   endtask
   task automatic test_reset();
      logic pu, po;
      ent_t e, a;
      rst = 1'b1;
      set_in(1'b1, 2'd3, 4'h3, 4'h5, 4'h9, 4'hf, 1'b1, 1'b1);
      bus.out_ready = 1'b0;
      bus.clr_sticky = 1'b0;
      for (int i = 0; i < 3; i++) tick(pu, po, e, a);
      total_cnt++; if (bus.count !== 2'd0) $display("FAIL reset_count got %0d exp 0", bus.count); else pass_cnt++;
      total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL reset_out_valid got %b exp 0", bus.out_valid); else pass_cnt++;
      total_cnt++; if (bus.out_result !== 4'd0) $display("FAIL reset_out_result got %h exp 0", bus.out_result); else pass_cnt++;
      total_cnt++; if (bus.in_ready !== 1'b0) $display("FAIL reset_in_ready got %b exp 0", bus.in_ready); else pass_cnt++;
      total_cnt++; if (bus.ovf_sticky !== 1'b0) $display("FAIL reset_sticky got %b exp 0", bus.ovf_sticky); else pass_cnt++;
      rst = 1'b0;
      bus.in_valid = 1'b0;
      tick(pu, po, e, a);
      total_cnt++; if (bus.in_ready !== 1'b1) $display("FAIL post_reset_in_ready got %b exp 1", bus.in_ready); else pass_cnt++;
      total_cnt++; if (bus.count !== 2'd0) $display("FAIL post_reset_count got %0d exp 0", bus.count); else pass_cnt++;
   endtask
   task automatic test_xor();
      logic pu, po;
      ent_t e, a;
      bus.out_ready = 1'b0;
      set_in(1'b1, 2'd2, 4'h0, 4'h0, 4'b1000, 4'h0, 1'b1, 1'b1);
      tick(pu, po, e, a);
      set_in(1'b1, 2'd2, 4'hf, 4'hf, 4'b0000, 4'hf, 1'b1, 1'b1);
      total_cnt++; if (bus.out_valid !== 1'b1) $display("FAIL xor_latency_valid got %b exp 1", bus.out_valid); else pass_cnt++;
      total_cnt++; if (bus.out_result !== 4'b1000) $display("FAIL xor_result got %b exp 1000", bus.out_result); else pass_cnt++;
      total_cnt++; if (bus.out_flags !== 4'b1000) $display("FAIL xor_flags got %b exp 1000", bus.out_flags); else pass_cnt++;
      tick(pu, po, e, a);
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick(pu, po, e, a);
         if (po) begin
            total_cnt++; if (a !== e) $display("FAIL xor_pop got %h exp %h", a, e); else pass_cnt++;
         end
      end
      total_cnt++; if (a.flg !== 4'b0100) $display("FAIL xor_zero_flags got %b exp 0100", a.flg); else pass_cnt++;
      total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL xor_drained got %b exp 0", bus.out_valid); else pass_cnt++;
   endtask
   task automatic test_add_ovf();
      logic pu, po;
      ent_t e, a;
      bus.out_ready = 1'b1;
      bus.clr_sticky = 1'b0;
      set_in(1'b1, 2'd3, 4'h0, 4'h0, 4'h0, 4'b1000, 1'b0, 1'b1);
      tick(pu, po, e, a);
      total_cnt++; if (bus.out_flags !== 4'b1001) $display("FAIL add_flags got %b exp 1001", bus.out_flags); else pass_cnt++;
      total_cnt++; if (bus.ovf_sticky !== 1'b1) $display("FAIL add_sticky_set got %b exp 1", bus.ovf_sticky); else pass_cnt++;
      bus.clr_sticky = 1'b1;
      tick(pu, po, e, a);
      if (po) begin
         total_cnt++; if (a !== e) $display("FAIL add_pop got %h exp %h", a, e); else pass_cnt++;
      end
      total_cnt++; if (bus.ovf_sticky !== 1'b0) $display("FAIL add_clear_wins got %b exp 0", bus.ovf_sticky); else pass_cnt++;
      bus.clr_sticky = 1'b0;
      bus.in_valid = 1'b0;
      tick(pu, po, e, a);
      if (po) begin
         total_cnt++; if (a !== e) $display("FAIL add_pop2 got %h exp %h", a, e); else pass_cnt++;
      end
      total_cnt++; if (bus.ovf_sticky !== msticky) $display("FAIL add_sticky_hold got %b exp %b", bus.ovf_sticky, msticky); else pass_cnt++;
   endtask
   task automatic test_backpressure();
      logic pu, po;
      ent_t e, a;
      int   npop = 0;
      bus.out_ready = 1'b0;
      set_in(1'b1, 2'd0, 4'h6, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0);
      tick(pu, po, e, a);
      set_in(1'b1, 2'd1, 4'h0, 4'ha, 4'h0, 4'h0, 1'b0, 1'b0);
      tick(pu, po, e, a);
      set_in(1'b1, 2'd3, 4'h0, 4'h0, 4'h0, 4'h0, 1'b1, 1'b0);
      total_cnt++; if (bus.count !== 2'd2) $display("FAIL bp_count got %0d exp 2", bus.count); else pass_cnt++;
      total_cnt++; if (bus.in_ready !== 1'b0) $display("FAIL bp_in_ready got %b exp 0", bus.in_ready); else pass_cnt++;
      tick(pu, po, e, a);
      total_cnt++; if (bus.count !== 2'd2) $display("FAIL bp_held_count got %0d exp 2", bus.count); else pass_cnt++;
      total_cnt++; if (bus.out_result !== 4'h6) $display("FAIL bp_head_stable got %h exp 6", bus.out_result); else pass_cnt++;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 10 && npop < 3; i++) begin
         tick(pu, po, e, a);
         if (pu) bus.in_valid = 1'b0;
         if (po) begin
            npop++;
            total_cnt++; if (a !== e) $display("FAIL bp_pop got %h exp %h", a, e); else pass_cnt++;
         end
      end
      total_cnt++; if (npop != 3 || bus.out_valid !== 1'b0) $display("FAIL bp_drain got %0d pops valid %b exp 3 pops valid 0", npop, bus.out_valid); else pass_cnt++;
   endtask
   task automatic test_back_to_back();
      logic pu, po;
      ent_t e, a;
      bus.out_ready = 1'b0;
      rand_in();
      tick(pu, po, e, a);
      bus.out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         rand_in();
         tick(pu, po, e, a);
         if (po) begin
            total_cnt++; if (a !== e) $display("FAIL b2b_pop got %h exp %h", a, e); else pass_cnt++;
         end
         total_cnt++; if (bus.count !== 2'd1) $display("FAIL b2b_count got %0d exp 1", bus.count); else pass_cnt++;
         total_cnt++; if (bus.ovf_sticky !== msticky) $display("FAIL b2b_sticky got %b exp %b", bus.ovf_sticky, msticky); else pass_cnt++;
      end
      bus.in_valid = 1'b0;
      for (int i = 0; i < 4 && mcount != 0; i++) begin
         tick(pu, po, e, a);
         if (po) begin
            total_cnt++; if (a !== e) $display("FAIL b2b_drain got %h exp %h", a, e); else pass_cnt++;
         end
      end
   endtask
   task automatic test_reset_mid();
      logic pu, po;
      ent_t e, a;
      bus.out_ready = 1'b0;
      for (int i = 0; i < 2; i++) begin
         rand_in();
         tick(pu, po, e, a);
      end
      total_cnt++; if (bus.count !== 2'd2) $display("FAIL mid_pre_count got %0d exp 2", bus.count); else pass_cnt++;
      rst = 1'b1;
      bus.out_ready = 1'b1;
      tick(pu, po, e, a);
      rst = 1'b0;
      bus.in_valid = 1'b0;
      total_cnt++; if (bus.count !== 2'd0) $display("FAIL mid_count got %0d exp 0", bus.count); else pass_cnt++;
      total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL mid_out_valid got %b exp 0", bus.out_valid); else pass_cnt++;
      for (int i = 0; i < 3; i++) begin
         if (i < 2) rand_in(); else bus.in_valid = 1'b0;
         bus.out_ready = i > 0;
         tick(pu, po, e, a);
         if (po) begin
            total_cnt++; if (a !== e) $display("FAIL mid_pop got %h exp %h", a, e); else pass_cnt++;
         end
      end
      for (int i = 0; i < 4 && mcount != 0; i++) begin
         tick(pu, po, e, a);
         if (po) begin
            total_cnt++; if (a !== e) $display("FAIL mid_drain got %h exp %h", a, e); else pass_cnt++;
         end
      end
      total_cnt++; if (bus.out_valid !== 1'b0) $display("FAIL mid_empty got %b exp 0", bus.out_valid); else pass_cnt++;
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog expired at %0t", $time);
      $fatal(1, "timeout");
   end
   initial begin
      test_reset();
      test_xor();
      test_add_ovf();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
